// File: rtl/serial_adder_nor.sv
// ---------------------------------------------------------------------------
// serial_adder_nor
// Bit-serial WIDTH-bit adder/subtractor. A single NOR-only full-adder cell is
// reused once per clock while the operands shift through it LSB first. This
// is the area-minimal datapath choice next to the flat combinational adders.
//
// Timing, with E the edge that accepts start:
//   edges E+1 .. E+WIDTH : one result bit per edge
//   cycle after E+WIDTH  : done=1, sum/cout/ovf valid
//   edge  E+WIDTH+1      : back to IDLE, ready=1
//   edge  E+WIDTH+2      : earliest edge that can accept the next start
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// serial_adder_nor_cell
// One-bit full adder built only from two-input NOR gates (nine gates).
//   w_n4 = XNOR(a, b)
//   o_s  = XNOR(w_n4, c) = a ^ b ^ c
//   o_co = NOR(w_n1, w_n5) = maj(a, b, c)
// The nets are wires because gate primitives drive nets, not variables.
// ---------------------------------------------------------------------------
module serial_adder_nor_cell (
    input  wire i_a,
    input  wire i_b,
    input  wire i_c,
    output wire o_s,
    output wire o_co
);

    wire w_n1;
    wire w_n2;
    wire w_n3;
    wire w_n4;
    wire w_n5;
    wire w_n6;
    wire w_n7;

    // First half adder: w_n1 = ~(a|b), w_n2 = ~a&b, w_n3 = a&~b
    nor g_n1 (w_n1, i_a, i_b);
    nor g_n2 (w_n2, i_a, w_n1);
    nor g_n3 (w_n3, i_b, w_n1);
    // w_n4 is a XNOR b
    nor g_n4 (w_n4, w_n2, w_n3);

    // Second half adder folds in the incoming carry
    nor g_n5 (w_n5, w_n4, i_c);
    nor g_n6 (w_n6, w_n4, w_n5);
    nor g_n7 (w_n7, i_c, w_n5);
    nor g_s  (o_s, w_n6, w_n7);

    // Carry out: (a|b) and not (exactly one of a,b set with no carry in)
    nor g_co (o_co, w_n1, w_n5);

endmodule

// ---------------------------------------------------------------------------
// serial_adder_nor (top)
// Controller plus operand/result shift registers around the NOR cell.
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module serial_adder_nor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter value on the edge that processes the MSB
    localparam logic [CNT_W-1:0] LP_LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_ready;
    logic             r_done;
    logic             r_cout;
    logic             r_ovf;

    wire              w_bit_s;
    wire              w_bit_co;

    // The single arithmetic cell, fed by the current LSBs and the carry
    serial_adder_nor_cell u_cell (
        .i_a  (r_a[0]),
        .i_b  (r_b[0]),
        .i_c  (r_carry),
        .o_s  (w_bit_s),
        .o_co (w_bit_co)
    );

    // Controller FSM: capture operands, shift one bit per edge, pulse done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
            r_sum   <= {WIDTH{1'b0}};
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + 1, so invert B here and
                        // force the initial carry; cin only matters for add.
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_cnt   <= {CNT_W{1'b0}};
                        r_sum   <= {WIDTH{1'b0}};
                        r_ready <= 1'b0;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end

                ST_SHIFT: begin
                    // Result bits enter at the top and walk down, so after
                    // WIDTH edges bit 0 of the result sits at sum[0].
                    r_sum   <= {w_bit_s, r_sum[WIDTH-1:1]};
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_carry <= w_bit_co;
                    r_cnt   <= r_cnt + LP_CNT_ONE;
                    if (r_cnt == LP_LAST_BIT) begin
                        // r_carry is the carry into the MSB at this point
                        r_ovf   <= r_carry ^ w_bit_co;
                        r_cout  <= w_bit_co;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end

                ST_DONE: begin
                    // done lasts exactly this one cycle; ready returns with IDLE
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
    assign sum   = r_sum;
    assign cout  = r_cout;
    assign ovf   = r_ovf;

endmodule
